aud_slot_serializer: RTL and testbench
======================================

// Module: aud_slot_serializer
// PURPOSE
//  Codec-side transmitter for the ADC serial link: serialises one parallel sample onto a
//  BCLK-aligned data line during the active (LRCK-low) slot, i.e. the transmit end that
//  adcRead receives. Muxed onto the iAUD_ADCDAT path for self-test loopback and test-tone
//  injection without the WM8731. The codec still owns BCLK/LRCK; this block only samples them.
// PARAMETERS
//  WS          16  sample width, bits, MSB first
//  SLOT_BITS   32  BCLK periods per LRCK half-frame; bits past WS(+delay) drive 0
//  SYNC_STAGES 2   flops in BCLK synchroniser and reset-release synchroniser (>=2)
// PORTS
//  iCLK_50       in   1          system clock, 50 MHz
//  AUD_ADCLRCK   in   1          reset, asynchronous, active-high (slot inactive while high)
//  iBCLK         in   1          codec bit clock, async to iCLK_50, <= 6.25 MHz
//  iSample       in   WS         sample to send, two's complement
//  iSampleValid  in   1          iSample valid; sampled from the oSampleReq cycle onward
//  oSampleReq    out  1          1-cycle pulse: slot opened, sample wanted
//  oDAT          out  1          serial data, changes only after detected BCLK falls
//  oBusy         out  1          high in ARM/SHIFT
//  oDone         out  1          1-cycle pulse after last data bit
//  oUnderrun     out  1          sticky until reset: no valid sample by first BCLK fall
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift reg, bit count, BCLK sync flops 0. Assert is async:
//   oDAT/oBusy drop the same cycle LRCK rises, even mid-shift (slot aborted, no oDone).
//  Release: internal reset deasserts SYNC_STAGES iCLK_50 edges after AUD_ADCLRCK falls.
//  BCLK: SYNC_STAGES-flop sync + prev flop; fall = prev&~cur. Flops reset to 0, so no false
//   fall at release. oDAT updates 1 cycle after detected fall: <= (SYNC_STAGES+2)*20 ns after
//   the real fall, which meets the codec sample point at the next BCLK rise.
//  FSM:
//   IDLE : first cycle out of reset: oSampleReq=1 -> REQ.
//   REQ  : valid -> shreg<=iSample -> ARM. Fall w/o valid -> shreg<=0, oUnderrun<=1, treat
//          that fall as the ARM fall (drive bit WS-1 = 0, cnt=1) -> SHIFT. Valid and fall in
//          the same cycle: valid wins, load iSample, drive its MSB, cnt=1 -> SHIFT.
//   ARM  : wait first fall (I2S 1-bit delay: LRCK changed on previous fall); on fall
//          oDAT<=shreg[WS-1], cnt=1 -> SHIFT.
//   SHIFT: each fall: cnt<WS -> oDAT<=shreg[WS-1-cnt], cnt++; cnt==WS -> oDAT<=0,
//          oDone pulse -> DONE.
//   DONE : oDAT=0; further falls ignored until reset. cnt saturates, never wraps.
//  Short slot (<WS+1 falls before LRCK rises): truncated, no oDone. Extra falls up to
//   SLOT_BITS carry 0. iSample is ignored after capture; holding it stable is not required.
// CONFIGURATION
//  AUD_SLOT_TX_LJ_EN defined: left-justified, no delay bit. On capture in REQ,
//   oDAT<=iSample[WS-1] at once and cnt=1; bit k follows fall k (k=1..WS-1); fall WS ->
//   oDAT<=0 + oDone. ARM is bypassed. In REQ, fall w/o valid -> underrun, zeros.
//  Undefined: I2S timing as above (MSB after first fall).
// STRUCTURE
//  aud_pkg: typedef enum logic[2:0] {IDLE,REQ,ARM,SHIFT,DONE} slot_state_t;
//   localparam I2S_DELAY_BITS=1; shared with adcRead/dacWrite rewrites.
//  Sub-module aud_rst_sync: async-assert/sync-deassert, SYNC_STAGES deep.
//  BCLK synchroniser and edge detect stay inline.
// TESTING
//  Slots: BCLK 3.125 MHz, LRCK period 64 BCLK. Reference receiver is the adcRead bit order.
//  1 I2S nominal: iSample=16'hA5C3 valid on req cycle -> falls 1..16 carry A5C3 MSB-first,
//    0 afterwards; oDone one pulse after fall 17; receiver model reads 16'hA5C3.
//  2 Underrun: iSampleValid held 0 -> oDAT=0 whole slot; oUnderrun 1 from first fall to LRCK
//    rise, then 0; next slot with valid 16'h7FFF sends cleanly, oUnderrun stays 0.
//  3 Late valid: valid 3 cycles after oSampleReq, before fall 1, iSample=16'h8001 -> 8001 sent.
//  4 Abort: LRCK rises after fall 8 -> oDAT/oBusy 0 same cycle, no oDone; next slot re-requests.
//  5 Collision: valid asserted exactly on the first detected fall, iSample=16'hC001 -> MSB on
//    that fall, full word sent, oUnderrun=0.
//  6 AUD_SLOT_TX_LJ_EN: iSample=16'h1234 -> MSB on oDAT within SYNC_STAGES+3 cycles of LRCK
//    fall; bits 14..0 on falls 1..15; 0 plus oDone after fall 16.

Source files
------------

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and constants for the audio serial-link blocks
// Contents: slot_state_t (slot transmitter FSM states), I2S_DELAY_BITS (BCLK periods
// between the LRCK edge and the MSB in I2S framing).
package aud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ARM,
    SHIFT,
    DONE
  } slot_state_t;

  localparam int I2S_DELAY_BITS = 1;

endpackage

// File: rtl/aud_rst_sync.sv
// rtl/aud_rst_sync.sv - reset synchroniser, asynchronous assert / synchronous release
// Ports:
//   iCLK_50  in   system clock
//   rstIn    in   asynchronous active-high reset source
//   rstOut   out  active-high reset; rises with rstIn, falls SYNC_STAGES clocks after it
module aud_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK_50,
  input  logic rstIn,
  output logic rstOut
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge iCLK_50 or posedge rstIn) begin
    if (rstIn) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rstOut = chain[SYNC_STAGES-1];

endmodule

// File: rtl/aud_slot_serializer.sv
// rtl/aud_slot_serializer.sv - serialises one sample onto the ADC data line per LRCK-low slot
// Build option: define AUD_SLOT_TX_LJ_EN for left-justified timing (MSB before the first
// BCLK fall); otherwise I2S timing (MSB after the first BCLK fall).
// Ports:
//   iCLK_50       in   system clock, 50 MHz
//   AUD_ADCLRCK   in   asynchronous active-high reset; slot is active while low
//   iBCLK         in   codec bit clock, asynchronous to iCLK_50
//   iSample       in   WS-bit sample, sent MSB first
//   iSampleValid  in   iSample valid, sampled from the oSampleReq cycle onward
//   oSampleReq    out  one-cycle pulse when the slot opens
//   oDAT          out  serial data, updated one cycle after a detected BCLK fall
//   oBusy         out  high while waiting for the first fall or shifting
//   oDone         out  one-cycle pulse after the last data bit
//   oUnderrun     out  sticky: no valid sample arrived by the first BCLK fall
module aud_slot_serializer
  import aud_pkg::*;
#(
  parameter int WS          = 16,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          iCLK_50,
  input  logic          AUD_ADCLRCK,
  input  logic          iBCLK,
  input  logic [WS-1:0] iSample,
  input  logic          iSampleValid,
  output logic          oSampleReq,
  output logic          oDAT,
  output logic          oBusy,
  output logic          oDone,
  output logic          oUnderrun
);

  localparam int            CW       = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] WS_CNT   = CW'(WS);
  localparam logic [CW-1:0] SLOT_CNT = CW'(SLOT_BITS);

  logic rst;

  aud_rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .iCLK_50(iCLK_50),
    .rstIn  (AUD_ADCLRCK),
    .rstOut (rst)
  );

  // BCLK synchroniser; all flops clear to 0 so a low BCLK at release is not seen as a fall
  logic [SYNC_STAGES-1:0] bclkSync;
  logic                   bclkPrev;
  logic                   bclkFall;

  assign bclkFall = bclkPrev & ~bclkSync[SYNC_STAGES-1];

  slot_state_t   state, stateNext;
  logic [WS-1:0] shreg, shregNext;
  logic [CW-1:0] cnt, cntNext;
  logic          dat, datNext;
  logic          done, doneNext;
  logic          req, reqNext;
  logic          underrun, underrunNext;

  always_ff @(posedge iCLK_50 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      dat      <= 1'b0;
      done     <= 1'b0;
      req      <= 1'b0;
      underrun <= 1'b0;
      bclkSync <= '0;
      bclkPrev <= 1'b0;
    end else begin
      state    <= stateNext;
      shreg    <= shregNext;
      cnt      <= cntNext;
      dat      <= datNext;
      done     <= doneNext;
      req      <= reqNext;
      underrun <= underrunNext;
      bclkSync <= {bclkSync[SYNC_STAGES-2:0], iBCLK};
      bclkPrev <= bclkSync[SYNC_STAGES-1];
    end
  end

  // The shift register moves left as bits go out, so the next bit is always shreg[WS-1].
  always_comb begin
    stateNext    = state;
    shregNext    = shreg;
    cntNext      = cnt;
    datNext      = dat;
    doneNext     = 1'b0;
    reqNext      = 1'b0;
    underrunNext = underrun;
    case (state)
      IDLE: begin
        reqNext   = 1'b1;
        stateNext = REQ;
      end
      REQ: begin
        if (iSampleValid) begin
`ifdef AUD_SLOT_TX_LJ_EN
          datNext   = iSample[WS-1];
          shregNext = iSample << 1;
          cntNext   = CW'(1);
          stateNext = SHIFT;
`else
          // A capture coinciding with the first fall is that fall's MSB, not an underrun
          if (bclkFall) begin
            datNext   = iSample[WS-1];
            shregNext = iSample << 1;
            cntNext   = CW'(1);
            stateNext = SHIFT;
          end else begin
            shregNext = iSample;
            stateNext = ARM;
          end
`endif
        end else if (bclkFall) begin
          // Too late: send a zero word, this fall standing in for the MSB fall
          shregNext    = '0;
          datNext      = 1'b0;
          underrunNext = 1'b1;
          cntNext      = CW'(1);
          stateNext    = SHIFT;
        end
      end
      ARM: begin
        if (bclkFall) begin
          datNext   = shreg[WS-1];
          shregNext = shreg << 1;
          cntNext   = CW'(1);
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (bclkFall) begin
          if (cnt < WS_CNT) begin
            datNext   = shreg[WS-1];
            shregNext = shreg << 1;
            cntNext   = cnt + 1'b1;
          end else begin
            datNext   = 1'b0;
            doneNext  = 1'b1;
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        datNext = 1'b0;
        if (bclkFall && cnt != SLOT_CNT) begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign oSampleReq = req;
  assign oDAT       = dat;
  assign oDone      = done;
  assign oUnderrun  = underrun;
  assign oBusy      = (state == ARM) || (state == SHIFT);

endmodule

// File: tb/tb_aud_slot_serializer.sv
// tb/tb_aud_slot_serializer.sv - self-checking bench for aud_slot_serializer
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_aud_slot_serializer;

  localparam int WS          = 16;
  localparam int SLOT_BITS   = 32;
  localparam int SYNC_STAGES = 2;
`ifdef AUD_SLOT_TX_LJ_EN
  localparam bit LJ         = 1'b1;
  localparam int FIRST_RISE = 1;
`else
  localparam bit LJ         = 1'b0;
  localparam int FIRST_RISE = 2;
`endif

  logic          iCLK_50 = 1'b0;
  logic          AUD_ADCLRCK;
  logic          iBCLK;
  logic [WS-1:0] iSample;
  logic          iSampleValid;
  logic          oSampleReq;
  logic          oDAT;
  logic          oBusy;
  logic          oDone;
  logic          oUnderrun;

  aud_slot_serializer #(
    .WS         (WS),
    .SLOT_BITS  (SLOT_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .iCLK_50     (iCLK_50),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .iBCLK       (iBCLK),
    .iSample     (iSample),
    .iSampleValid(iSampleValid),
    .oSampleReq  (oSampleReq),
    .oDAT        (oDAT),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oUnderrun   (oUnderrun)
  );

  always #10 iCLK_50 = ~iCLK_50;

  // 3.125 MHz BCLK, edges offset 7 ns from the 10 ns grid of iCLK_50 edges
  initial begin
    iBCLK = 1'b0;
    #7;
    forever #160 iBCLK = ~iBCLK;
  end

  typedef struct {
    logic [WS-1:0] word;
    logic          underrun;
    int            doneFall;
  } exp_t;

  exp_t sbQ[$];

  int assertCnt = 0;
  int failCnt   = 0;
  int slotId    = 0;

  int            fallSlot  = -1;
  int            fallCnt   = 0;
  int            rxSlot    = -1;
  int            riseCnt   = 0;
  int            extraOnes = 0;
  logic [WS-1:0] rxWord    = '0;
  int            doneSlot  = -1;
  int            doneCnt   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Falls counted per slot; the fall that lowers LRCK is not counted.
  always @(negedge iBCLK) begin
    if (fallSlot != slotId) begin
      fallSlot = slotId;
      fallCnt  = 0;
    end
    if (!AUD_ADCLRCK) fallCnt++;
  end

  // Receiver: samples oDAT on BCLK rises in adcRead bit order
  always @(posedge iBCLK) begin
    if (rxSlot != slotId) begin
      rxSlot    = slotId;
      riseCnt   = 0;
      extraOnes = 0;
      rxWord    = '0;
    end
    if (!AUD_ADCLRCK) begin
      riseCnt++;
      if (riseCnt >= FIRST_RISE && riseCnt < FIRST_RISE + WS) rxWord = {rxWord[WS-2:0], oDAT};
      else if (oDAT) extraOnes++;
    end
  end

  // Scoreboard: each oDone pops the expectation pushed when the slot was driven
  always @(negedge iCLK_50) begin
    exp_t e;
    if (doneSlot != slotId) begin
      doneSlot = slotId;
      doneCnt  = 0;
    end
    if (oDone) begin
      doneCnt++;
      if (sbQ.size() == 0) begin
        checkVal("sbEmpty", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkVal("rxWord", rxWord, e.word);
        checkVal("doneFall", fallCnt, e.doneFall);
        checkVal("underrunAtDone", oUnderrun, e.underrun);
        checkVal("datAtDone", oDAT, 32'd0);
      end
    end
  end

  task automatic waitFalls(input int n);
    bit reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      @(negedge iCLK_50);
      reached = (fallSlot == slotId) && (fallCnt >= n);
    end
    if (!reached) checkVal("fallTimeout", 32'd0, 32'd1);
  endtask

  task automatic driveSample(input logic [WS-1:0] smp);
    iSample      = smp;
    iSampleValid = 1'b1;
    @(negedge iCLK_50);
    iSampleValid = 1'b0;
    iSample      = WS'($urandom);
  endtask

  task automatic runSlot(input logic [WS-1:0] smp, input bit giveValid, input int validDly,
                         input bit collide, input int abortFall);
    exp_t e;
    bit   gotReq = 1'b0;
    @(negedge iBCLK);
    #1;
    slotId++;
    AUD_ADCLRCK = 1'b0;
    for (int i = 0; i < 10 && !gotReq; i++) begin
      @(negedge iCLK_50);
      gotReq = oSampleReq;
    end
    checkVal("sampleReq", gotReq, 32'd1);
    e.word     = giveValid ? smp : '0;
    e.underrun = !giveValid;
    e.doneFall = (LJ && giveValid) ? WS : WS + 1;
    if (abortFall == 0) sbQ.push_back(e);
    if (!giveValid) begin
      @(negedge iCLK_50);
      checkVal("reqPulse", oSampleReq, 32'd0);
    end else if (collide) begin
      @(negedge iCLK_50);
      checkVal("reqPulse", oSampleReq, 32'd0);
      // Land valid in the one cycle the synchronised first fall is visible
      @(negedge iBCLK);
      repeat (SYNC_STAGES) @(negedge iCLK_50);
      checkVal("busyBeforeCollide", oBusy, 32'd0);
      driveSample(smp);
    end else begin
      if (validDly > 0) begin
        @(negedge iCLK_50);
        checkVal("reqPulse", oSampleReq, 32'd0);
        repeat (validDly - 1) @(negedge iCLK_50);
      end
      driveSample(smp);
      checkVal("busyAfterCapture", oBusy, 32'd1);
      checkVal("datAfterCapture", oDAT, LJ ? smp[WS-1] : 1'b0);
    end
    if (abortFall > 0) begin
      waitFalls(abortFall);
      repeat (3) @(negedge iCLK_50);
      checkVal("busyPreAbort", oBusy, 32'd1);
      checkVal("datPreAbort", oDAT, LJ ? smp[WS-1-abortFall] : smp[WS-abortFall]);
      #1 AUD_ADCLRCK = 1'b1;
      #1;
      checkVal("busyAbort", oBusy, 32'd0);
      checkVal("datAbort", oDAT, 32'd0);
      checkVal("doneAbort", doneCnt, 32'd0);
    end else begin
      waitFalls(SLOT_BITS);
      repeat (3) @(negedge iCLK_50);
      checkVal("slotDone", doneCnt, 32'd1);
      checkVal("extraOnes", extraOnes, 32'd0);
      checkVal("underrunEnd", oUnderrun, !giveValid);
      checkVal("datEnd", oDAT, 32'd0);
      #1 AUD_ADCLRCK = 1'b1;
      #1;
      checkVal("busyAfterRise", oBusy, 32'd0);
      checkVal("underrunAfterRise", oUnderrun, 32'd0);
    end
    repeat (8) @(negedge iBCLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    AUD_ADCLRCK  = 1'b1;
    iSample      = '0;
    iSampleValid = 1'b0;
    repeat (5) @(negedge iCLK_50);
    checkVal("resetOutputs", {oSampleReq, oDAT, oBusy, oDone, oUnderrun}, 32'd0);

    runSlot(16'hA5C3, 1'b1, 0, 1'b0, 0);
    runSlot(16'h0000, 1'b0, 0, 1'b0, 0);
    runSlot(16'h7FFF, 1'b1, 0, 1'b0, 0);
    runSlot(16'h8001, 1'b1, 3, 1'b0, 0);
    runSlot(16'h0180, 1'b1, 0, 1'b0, 8);
`ifndef AUD_SLOT_TX_LJ_EN
    runSlot(16'hC001, 1'b1, 0, 1'b1, 0);
`endif
    runSlot(16'h1234, 1'b1, 0, 1'b0, 0);

    checkVal("sbDrained", sbQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
